// File: rtl/fft_frame_sequencer_if.sv
// Stream bundle for the FFT frame sequencer: audio tap in, FFT config and
// FFT input streams out, FFT result tap in.
interface fft_frame_sequencer_if;
  logic [23:0] s_audio_data;
  logic        s_audio_valid;
  logic        s_audio_ready;
  logic        s_audio_last;
  logic [31:0] m_fft_tdata;
  logic        m_fft_tvalid;
  logic        m_fft_tlast;
  logic        m_fft_tready;
  logic [15:0] m_cfg_tdata;
  logic        m_cfg_tvalid;
  logic        m_cfg_tready;
  logic        fft_out_valid;
  logic        fft_out_last;

  modport master (
    input  s_audio_data, s_audio_valid, s_audio_ready, s_audio_last,
    output m_fft_tdata, m_fft_tvalid, m_fft_tlast,
    input  m_fft_tready,
    output m_cfg_tdata, m_cfg_tvalid,
    input  m_cfg_tready,
    input  fft_out_valid, fft_out_last
  );

  modport slave (
    output s_audio_data, s_audio_valid, s_audio_ready, s_audio_last,
    input  m_fft_tdata, m_fft_tvalid, m_fft_tlast,
    output m_fft_tready,
    input  m_cfg_tdata, m_cfg_tvalid,
    output m_cfg_tready,
    output fft_out_valid, fft_out_last
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Configures the FFT core once, then captures mono audio frames into the FFT input
// stream, waiting for each FFT output frame (or a timeout) before arming the next.
module fft_frame_sequencer #(
  parameter int          FFT_SIZE  = 2048,
  parameter int          LOG2_SIZE = 11,
  parameter int          DECIM     = 1,
  parameter int          HOP_GAP   = 0,
  parameter bit          CHANNEL   = 1'b0,
  parameter logic [15:0] CFG_WORD  = 16'h0001,
  parameter int          TIMEOUT   = 65535
) (
  input  logic                  axis_clk,
  input  logic                  axis_resetn,
  input  logic                  enable,
  fft_frame_sequencer_if.master bus,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  timeout_flag,
  output logic [7:0]            overrun_count,
  output logic [15:0]           frame_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (HOP_GAP > 1) ? $clog2(HOP_GAP) : 1;
  localparam logic [LOG2_SIZE-1:0] LAST_IDX = LOG2_SIZE'(FFT_SIZE - 1);
  localparam logic [3:0]           DEC_LAST = 4'(DECIM - 1);
  localparam logic [TW-1:0]        TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]        GAP_LAST = GW'(HOP_GAP - 1);

  typedef enum logic [2:0] {S_CONFIG, S_IDLE, S_CAPTURE, S_WAIT_OUT, S_GAP} state_e;

  state_e                 state_q, state_d, after_out_s;
  logic                   cfg_valid_q, cfg_valid_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   hold_last_q, hold_last_d;
  logic [15:0]            hold_data_q, hold_data_d;
  logic [LOG2_SIZE-1:0]   load_cnt_q, load_cnt_d;
  logic                   cap_full_q, cap_full_d;
  logic [3:0]             dec_cnt_q, dec_cnt_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic                   frame_start_q, frame_start_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [7:0]             overrun_q, overrun_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   sel_s, fwd_s, drain_s, unused_lsb;

  assign sel_s       = bus.s_audio_valid & bus.s_audio_ready & (bus.s_audio_last == CHANNEL);
  assign fwd_s       = sel_s & (dec_cnt_q == 4'd0);
  assign drain_s     = hold_valid_q & bus.m_fft_tready;
  assign after_out_s = ((HOP_GAP > 0) && enable) ? S_GAP : S_IDLE;
  assign unused_lsb  = ^bus.s_audio_data[7:0];

  // Next-state, hold register, counters and status pulses
  always_comb begin
    state_d       = state_q;
    cfg_valid_d   = 1'b0;
    hold_valid_d  = hold_valid_q & ~drain_s;
    hold_last_d   = hold_last_q & ~drain_s;
    hold_data_d   = hold_data_q;
    load_cnt_d    = load_cnt_q;
    cap_full_d    = cap_full_q;
    dec_cnt_d     = dec_cnt_q;
    timer_d       = timer_q;
    gap_cnt_d     = gap_cnt_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    timeout_d     = timeout_q;
    overrun_d     = overrun_q;
    frame_cnt_d   = frame_cnt_q;
    case (state_q)
      S_CONFIG: begin
        if (cfg_valid_q && bus.m_cfg_tready) begin
          state_d = S_IDLE;
        end else begin
          cfg_valid_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (enable) begin
          state_d       = S_CAPTURE;
          frame_start_d = 1'b1;
          dec_cnt_d     = 4'd0;
          load_cnt_d    = '0;
          cap_full_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (sel_s) begin
          dec_cnt_d = (dec_cnt_q == DEC_LAST) ? 4'd0 : dec_cnt_q + 4'd1;
        end else begin
          dec_cnt_d = dec_cnt_q;
        end
        // Once the last word of the frame is loaded, later samples are simply ignored.
        if (fwd_s && !cap_full_q) begin
          if (!hold_valid_q || bus.m_fft_tready) begin
            hold_valid_d = 1'b1;
            hold_data_d  = bus.s_audio_data[23:8];
            hold_last_d  = (load_cnt_q == LAST_IDX);
            cap_full_d   = (load_cnt_q == LAST_IDX);
            load_cnt_d   = load_cnt_q + LOG2_SIZE'(1);
          end else begin
            overrun_d = (overrun_q == 8'hFF) ? overrun_q : overrun_q + 8'd1;
          end
        end else begin
          hold_data_d = hold_data_q;
        end
        if (drain_s && hold_last_q) begin
          state_d = S_WAIT_OUT;
          timer_d = '0;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_WAIT_OUT: begin
        timer_d   = timer_q + TW'(1);
        gap_cnt_d = '0;
        if (bus.fft_out_valid && bus.fft_out_last) begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          state_d      = after_out_s;
        end else if (timer_q == TO_LAST) begin
          frame_done_d = 1'b1;
          timeout_d    = 1'b1;
          state_d      = after_out_s;
        end else begin
          state_d = S_WAIT_OUT;
        end
      end
      S_GAP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (sel_s) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_CONFIG;
      end
    endcase
    busy_d = (state_d == S_CAPTURE) || (state_d == S_WAIT_OUT);
  end

  // State and datapath registers
  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q       <= S_CONFIG;
      cfg_valid_q   <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_last_q   <= 1'b0;
      hold_data_q   <= 16'h0000;
      load_cnt_q    <= '0;
      cap_full_q    <= 1'b0;
      dec_cnt_q     <= 4'd0;
      timer_q       <= '0;
      gap_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      overrun_q     <= 8'd0;
      frame_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      cfg_valid_q   <= cfg_valid_d;
      hold_valid_q  <= hold_valid_d;
      hold_last_q   <= hold_last_d;
      hold_data_q   <= hold_data_d;
      load_cnt_q    <= load_cnt_d;
      cap_full_q    <= cap_full_d;
      dec_cnt_q     <= dec_cnt_d;
      timer_q       <= timer_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
      overrun_q     <= overrun_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.m_cfg_tvalid = cfg_valid_q;
  assign bus.m_cfg_tdata  = cfg_valid_q ? CFG_WORD : 16'h0000;
  assign bus.m_fft_tvalid = hold_valid_q;
  assign bus.m_fft_tlast  = hold_last_q;
  assign bus.m_fft_tdata  = {16'h0000, hold_data_q};
  assign frame_start      = frame_start_q;
  assign frame_done       = frame_done_q;
  assign busy             = busy_q;
  assign timeout_flag     = timeout_q;
  assign overrun_count    = overrun_q;
  assign frame_count      = frame_cnt_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench: table-driven capture/overrun vectors on an 8-point instance, plus
// hand-written config, timeout, decimation/gap and enable/reset sequences.
module tb_fft_frame_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  always #5 clk = ~clk;

  fft_frame_sequencer_if ia ();
  fft_frame_sequencer_if ib ();

  logic        fs_a, fd_a, busy_a, to_a, fs_b, fd_b, busy_b, to_b;
  logic [7:0]  ovr_a, ovr_b;
  logic [15:0] fc_a, fc_b;

  fft_frame_sequencer #(.FFT_SIZE(8), .LOG2_SIZE(3), .DECIM(1), .HOP_GAP(0),
                        .CHANNEL(1'b0), .CFG_WORD(16'h0001), .TIMEOUT(100)) dut_a (
    .axis_clk(clk), .axis_resetn(rst_n), .enable(en_a), .bus(ia),
    .frame_start(fs_a), .frame_done(fd_a), .busy(busy_a), .timeout_flag(to_a),
    .overrun_count(ovr_a), .frame_count(fc_a));

  fft_frame_sequencer #(.FFT_SIZE(8), .LOG2_SIZE(3), .DECIM(2), .HOP_GAP(2),
                        .CHANNEL(1'b0), .CFG_WORD(16'h0001), .TIMEOUT(100)) dut_b (
    .axis_clk(clk), .axis_resetn(rst_n), .enable(en_b), .bus(ib),
    .frame_start(fs_b), .frame_done(fd_b), .busy(busy_b), .timeout_flag(to_b),
    .overrun_count(ovr_b), .frame_count(fc_b));

  assign ib.s_audio_data  = ia.s_audio_data;
  assign ib.s_audio_valid = ia.s_audio_valid;
  assign ib.s_audio_ready = ia.s_audio_ready;
  assign ib.s_audio_last  = ia.s_audio_last;
  assign ib.m_fft_tready  = ia.m_fft_tready;
  assign ib.m_cfg_tready  = ia.m_cfg_tready;
  assign ib.fft_out_valid = ia.fft_out_valid;
  assign ib.fft_out_last  = ia.fft_out_last;

  typedef struct {
    logic        vld;
    logic        lst;
    logic [7:0]  k;
    logic        rdy;
    logic        e_v;
    logic        e_last;
    logic [15:0] e_re;
    logic [7:0]  e_ovr;
  } vec_t;

  vec_t        tv[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          tlast_cyc = -1;
  int          fs_cnt_a = 0;
  logic [15:0] qa[$];
  logic        qa_last[$];
  logic [15:0] qb[$];
  logic        qb_last[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ia.m_fft_tvalid && ia.m_fft_tready) begin
      qa.push_back(ia.m_fft_tdata[15:0]);
      qa_last.push_back(ia.m_fft_tlast);
      if (ia.m_fft_tlast) tlast_cyc <= cyc + 1;
    end
    if (ib.m_fft_tvalid && ib.m_fft_tready) begin
      qb.push_back(ib.m_fft_tdata[15:0]);
      qb_last.push_back(ib.m_fft_tlast);
    end
    if (fs_a) fs_cnt_a <= fs_cnt_a + 1;
  end

  function automatic vec_t mk(input logic vld, input logic lst, input logic [7:0] k,
                              input logic rdy, input logic e_v, input logic e_last,
                              input logic [15:0] e_re, input logic [7:0] e_ovr);
    vec_t v;
    v.vld = vld; v.lst = lst; v.k = k; v.rdy = rdy;
    v.e_v = e_v; v.e_last = e_last; v.e_re = e_re; v.e_ovr = e_ovr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic audio(input logic v, input logic lst, input logic [7:0] k);
    ia.s_audio_valid = v;
    ia.s_audio_last  = lst;
    ia.s_audio_data  = {8'h00, k, 8'h00};
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      audio(tv[i].vld, tv[i].lst, tv[i].k);
      ia.m_fft_tready = tv[i].rdy;
      tick();
      chk($sformatf("vec%0d_tvalid", i), {31'd0, ia.m_fft_tvalid}, {31'd0, tv[i].e_v});
      chk($sformatf("vec%0d_tlast", i), {31'd0, ia.m_fft_tlast}, {31'd0, tv[i].e_last});
      if (tv[i].e_v) chk($sformatf("vec%0d_tdata", i), ia.m_fft_tdata, {16'h0000, tv[i].e_re});
      chk($sformatf("vec%0d_overrun", i), {24'd0, ovr_a}, {24'd0, tv[i].e_ovr});
    end
    audio(1'b0, 1'b0, 8'd0);
    ia.m_fft_tready = 1'b1;
  endtask

  task automatic out_pulse();
    ia.fft_out_valid = 1'b1;
    ia.fft_out_last  = 1'b1;
    tick();
    ia.fft_out_valid = 1'b0;
    ia.fft_out_last  = 1'b0;
  endtask

  initial begin
    int seen;
    int fs0;
    // frame 1: alternating L/R, FFT always ready
    for (int k = 1; k <= 8; k++) begin
      tv.push_back(mk(1'b1, 1'b0, 8'(k), 1'b1, 1'b1, (k == 8), 16'(k), 8'd0));
      tv.push_back(mk(1'b1, 1'b1, 8'(8'h80 + k), 1'b1, 1'b0, 1'b0, 16'd0, 8'd0));
    end
    // frame 2: back-pressure with two drops, then same-cycle drain and load
    tv.push_back(mk(1'b1, 1'b0, 8'd1,   1'b0, 1'b1, 1'b0, 16'd1,  8'd0));
    tv.push_back(mk(1'b1, 1'b1, 8'h81,  1'b0, 1'b1, 1'b0, 16'd1,  8'd0));
    tv.push_back(mk(1'b1, 1'b0, 8'd2,   1'b0, 1'b1, 1'b0, 16'd1,  8'd1));
    tv.push_back(mk(1'b1, 1'b0, 8'd3,   1'b0, 1'b1, 1'b0, 16'd1,  8'd2));
    tv.push_back(mk(1'b1, 1'b0, 8'd4,   1'b1, 1'b1, 1'b0, 16'd4,  8'd2));
    tv.push_back(mk(1'b1, 1'b0, 8'd5,   1'b1, 1'b1, 1'b0, 16'd5,  8'd2));
    tv.push_back(mk(1'b1, 1'b0, 8'd6,   1'b1, 1'b1, 1'b0, 16'd6,  8'd2));
    tv.push_back(mk(1'b1, 1'b0, 8'd7,   1'b1, 1'b1, 1'b0, 16'd7,  8'd2));
    tv.push_back(mk(1'b1, 1'b0, 8'd8,   1'b1, 1'b1, 1'b0, 16'd8,  8'd2));
    tv.push_back(mk(1'b1, 1'b0, 8'd9,   1'b1, 1'b1, 1'b0, 16'd9,  8'd2));
    tv.push_back(mk(1'b1, 1'b0, 8'd10,  1'b1, 1'b1, 1'b1, 16'd10, 8'd2));
    tv.push_back(mk(1'b1, 1'b0, 8'd11,  1'b1, 1'b0, 1'b0, 16'd0,  8'd2));
    tv.push_back(mk(1'b1, 1'b0, 8'd12,  1'b0, 1'b0, 1'b0, 16'd0,  8'd2));

    audio(1'b0, 1'b0, 8'd0);
    ia.s_audio_ready = 1'b1;
    ia.m_fft_tready  = 1'b1;
    ia.m_cfg_tready  = 1'b0;
    ia.fft_out_valid = 1'b0;
    ia.fft_out_last  = 1'b0;

    // reset state, then config held off for 5 cycles
    #20;
    chk("rst_cfg_tvalid", {31'd0, ia.m_cfg_tvalid}, 32'd0);
    chk("rst_tvalid", {31'd0, ia.m_fft_tvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_frame_count", {16'd0, fc_a}, 32'd0);
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("cfg_tvalid_c%0d", c), {31'd0, ia.m_cfg_tvalid}, 32'd1);
      chk($sformatf("cfg_tdata_c%0d", c), {16'd0, ia.m_cfg_tdata}, 32'h0001);
    end
    chk("cfg_b_tdata", {16'd0, ib.m_cfg_tdata}, 32'h0001);
    ia.m_cfg_tready = 1'b1;
    tick();
    chk("cfg_tvalid_done", {31'd0, ia.m_cfg_tvalid}, 32'd0);
    chk("cfg_b_tvalid_done", {31'd0, ib.m_cfg_tvalid}, 32'd0);
    ia.m_cfg_tready = 1'b0;

    // frame 1
    en_a = 1'b1;
    tick();
    chk("f1_frame_start", {31'd0, fs_a}, 32'd1);
    chk("f1_busy", {31'd0, busy_a}, 32'd1);
    en_a = 1'b0;
    apply(0, 15);
    chk("f1_busy_wait", {31'd0, busy_a}, 32'd1);
    chk("f1_start_count", fs_cnt_a, 32'd1);
    out_pulse();
    chk("f1_frame_done", {31'd0, fd_a}, 32'd1);
    chk("f1_frame_count", {16'd0, fc_a}, 32'd1);
    chk("f1_timeout", {31'd0, to_a}, 32'd0);
    tick();
    chk("f1_done_pulse", {31'd0, fd_a}, 32'd0);
    chk("f1_idle_busy", {31'd0, busy_a}, 32'd0);

    // frame 2: overrun, then FFT output never completes
    en_a = 1'b1;
    tick();
    chk("f2_frame_start", {31'd0, fs_a}, 32'd1);
    en_a = 1'b0;
    apply(16, 28);
    seen = 0;
    for (int i = 0; i < 150 && seen == 0; i++) begin
      tick();
      if (fd_a) seen = 1;
    end
    chk("to_done_seen", seen, 32'd1);
    chk("to_latency", cyc - tlast_cyc, 32'd100);
    chk("to_flag", {31'd0, to_a}, 32'd1);
    chk("to_frame_count", {16'd0, fc_a}, 32'd1);
    chk("to_overrun", {24'd0, ovr_a}, 32'd2);
    chk("to_busy", {31'd0, busy_a}, 32'd0);

    // DECIM=2 instance: only even left samples, then hop gap of 2 before re-arm
    qb.delete();
    qb_last.delete();
    en_b = 1'b1;
    tick();
    chk("dec_frame_start", {31'd0, fs_b}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      audio(1'b1, 1'b0, 8'(k));
      tick();
      audio(1'b1, 1'b1, 8'(8'hC0 + k));
      tick();
    end
    audio(1'b0, 1'b0, 8'd0);
    chk("dec_words", qb.size(), 32'd8);
    for (int i = 0; i < 8 && i < qb.size(); i++) begin
      chk($sformatf("dec_word%0d", i), {16'd0, qb[i]}, 32'(2 * i));
      chk($sformatf("dec_last%0d", i), {31'd0, qb_last[i]}, {31'd0, (i == 7)});
    end
    chk("dec_busy_wait", {31'd0, busy_b}, 32'd1);
    chk("dec_a_idle", {31'd0, ia.m_fft_tvalid}, 32'd0);
    out_pulse();
    chk("dec_frame_done", {31'd0, fd_b}, 32'd1);
    chk("dec_frame_count", {16'd0, fc_b}, 32'd1);
    chk("dec_gap_busy", {31'd0, busy_b}, 32'd0);
    audio(1'b1, 1'b0, 8'd20);
    tick();
    audio(1'b1, 1'b1, 8'hC0);
    tick();
    audio(1'b1, 1'b0, 8'd21);
    tick();
    audio(1'b0, 1'b0, 8'd0);
    chk("gap_no_start", {31'd0, fs_b}, 32'd0);
    chk("gap_idle_busy", {31'd0, busy_b}, 32'd0);
    tick();
    chk("gap_rearm_start", {31'd0, fs_b}, 32'd1);
    audio(1'b1, 1'b0, 8'd22);
    tick();
    audio(1'b0, 1'b0, 8'd0);
    chk("gap_first_tvalid", {31'd0, ib.m_fft_tvalid}, 32'd1);
    chk("gap_first_tdata", ib.m_fft_tdata, 32'h0000_0016);
    chk("dec_overrun", {24'd0, ovr_b}, 32'd0);
    chk("dec_timeout", {31'd0, to_b}, 32'd0);
    en_b = 1'b0;

    // enable dropped mid-capture: frame finishes, nothing re-arms
    qa.delete();
    qa_last.delete();
    fs0 = fs_cnt_a;
    en_a = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) en_a = 1'b0;
      audio(1'b1, 1'b0, 8'(k));
      tick();
    end
    audio(1'b0, 1'b0, 8'd0);
    tick();
    chk("en_words", qa.size(), 32'd8);
    for (int i = 0; i < 8 && i < qa.size(); i++) begin
      chk($sformatf("en_word%0d", i), {16'd0, qa[i]}, 32'(i + 1));
      chk($sformatf("en_last%0d", i), {31'd0, qa_last[i]}, {31'd0, (i == 7)});
    end
    chk("en_busy_wait", {31'd0, busy_a}, 32'd1);
    out_pulse();
    chk("en_frame_count", {16'd0, fc_a}, 32'd2);
    for (int i = 0; i < 3; i++) tick();
    chk("en_idle_busy", {31'd0, busy_a}, 32'd0);
    chk("en_start_once", fs_cnt_a - fs0, 32'd1);

    // reset at word 4 of the next run
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      audio(1'b1, 1'b0, 8'(k));
      tick();
    end
    audio(1'b0, 1'b0, 8'd0);
    chk("pre_rst_tdata", ia.m_fft_tdata, 32'h0000_0004);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", {31'd0, ia.m_fft_tvalid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("mid_rst_frame_count", {16'd0, fc_a}, 32'd0);
    chk("mid_rst_overrun", {24'd0, ovr_a}, 32'd0);
    chk("mid_rst_timeout", {31'd0, to_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("recfg_tvalid", {31'd0, ia.m_cfg_tvalid}, 32'd1);
    chk("recfg_tdata", {16'd0, ia.m_cfg_tdata}, 32'h0001);
    ia.m_cfg_tready = 1'b1;
    tick();
    chk("recfg_done", {31'd0, ia.m_cfg_tvalid}, 32'd0);
    chk("recfg_busy", {31'd0, busy_a}, 32'd0);
    ia.m_cfg_tready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
